pipeline2_decode: RTL

//  Decode stage (ID) of the pipelined processor; consumes instr/PC from the fetch stage and closes the

---
 rtl/pipeline2_decode.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pipeline2_decode.sv
// Decode stage: register file with WB bypass, load-use hazard detection and BEQ/JMP resolution.
// Redirects go back to fetch; decoded operands leave through a registered ID/EX slot.
module pipeline2_decode #(
  parameter int unsigned PC_WIDTH     = 16,
  parameter int unsigned INSTR_WIDTH  = 32,
  parameter int unsigned N_REGS       = 32,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                   clk_in,
  input  logic                   RST,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [PC_WIDTH-1:0]    pc_in,
  input  logic                   wb_en,
  input  logic [4:0]             wb_addr,
  input  logic [31:0]            wb_data,
  output logic                   pc_chg,
  output logic [PC_WIDTH-1:0]    pc_tgt,
  output logic                   ex_valid,
  output logic [5:0]             ex_op,
  output logic [4:0]             ex_rd,
  output logic [31:0]            ex_rs_val,
  output logic [31:0]            ex_rt_val,
  output logic [31:0]            ex_imm,
  output logic [PC_WIDTH-1:0]    ex_pc
);

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_JMP = 6'h02;
  localparam logic [5:0] OP_NOP = 6'h00;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [31:0]         regs [N_REGS];
  logic [0:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [5:0]          op;
  logic [4:0]          rd, rs, rt;
  logic [31:0]         imm_sext, rs_val, rt_val;
  logic                hazard, redirect, bubble;

  logic                pc_chg_d, valid_d;
  logic [PC_WIDTH-1:0] pc_tgt_d, pc_d;
  logic [5:0]          op_d;
  logic [4:0]          rd_d;
  logic [31:0]         rs_val_d, rt_val_d, imm_d;

  assign op       = instr_in[31:26];
  assign rd       = instr_in[25:21];
  assign rs       = instr_in[20:16];
  assign rt       = instr_in[15:11];
  assign imm_sext = {{16{instr_in[15]}}, instr_in[15:0]};

  // A WB write landing this edge is visible to the instruction decoded this cycle.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs != 5'd0) rs_val = (wb_en && wb_addr == rs) ? wb_data : regs[rs];
    if (rt != 5'd0) rt_val = (wb_en && wb_addr == rt) ? wb_data : regs[rt];
  end

  assign hazard = ex_valid && (ex_op == OP_LW) && (ex_rd != 5'd0) &&
                  ((ex_rd == rs) || (ex_rd == rt));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    redirect = 1'b0;
    bubble   = 1'b0;
    pc_tgt_d = '0;

    if (state_q == ST_FLUSH) begin
      bubble = 1'b1;
      if (cnt_q == '0) state_d = ST_RUN;
      else             cnt_d   = cnt_q - 1'b1;
    end else if (hazard) begin
      // Hazard wins over a branch: the branch would compare stale operands.
      bubble   = 1'b1;
      redirect = 1'b1;
      pc_tgt_d = pc_in;
    end else if (op == OP_BEQ && rs_val == rt_val) begin
      redirect = 1'b1;
      pc_tgt_d = pc_in + PC_WIDTH'(1) + imm_sext[PC_WIDTH-1:0];
    end else if (op == OP_JMP) begin
      redirect = 1'b1;
      pc_tgt_d = imm_sext[PC_WIDTH-1:0];
    end

    if (redirect) begin
      state_d = ST_FLUSH;
      cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
    end

    pc_chg_d = redirect;
    valid_d  = !bubble;
    op_d     = bubble ? OP_NOP : op;
    rd_d     = (bubble || op == OP_NOP) ? 5'd0 : rd;
    rs_val_d = bubble ? '0 : rs_val;
    rt_val_d = bubble ? '0 : rt_val;
    imm_d    = bubble ? '0 : imm_sext;
    pc_d     = bubble ? '0 : pc_in;
  end

  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(N_REGS); i++) regs[i] <= '0;
    end else if (wb_en && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      pc_chg    <= 1'b0;
      pc_tgt    <= '0;
      ex_valid  <= 1'b0;
      ex_op     <= '0;
      ex_rd     <= '0;
      ex_rs_val <= '0;
      ex_rt_val <= '0;
      ex_imm    <= '0;
      ex_pc     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_chg    <= pc_chg_d;
      pc_tgt    <= pc_tgt_d;
      ex_valid  <= valid_d;
      ex_op     <= op_d;
      ex_rd     <= rd_d;
      ex_rs_val <= rs_val_d;
      ex_rt_val <= rt_val_d;
      ex_imm    <= imm_d;
      ex_pc     <= pc_d;
    end
  end

endmodule
